// File: rtl/cic_pkg.sv
// cic_pkg: helpers shared by the CIC interpolator and decimator.
//   count_width()  - rate-counter width for a power-of-two ratio
//   shift_clamp()  - output right-shift amount derived from Gain, floored at 0
//   saturate()     - clamp a wide signed value into a narrower signed range
// Callers sign-extend into SAT_WIDTH before saturating, so filters
// up to SAT_WIDTH bits of internal width are supported.
package cic_pkg;

    localparam int DEFAULT_RATIO = 16;
    localparam int COUNT_WIDTH   = $clog2(DEFAULT_RATIO);
    localparam int SAT_WIDTH     = 128;

    function automatic int count_width(input int ratio);
        return $clog2(ratio);
    endfunction

    // A Gain beyond the available headroom would ask for a negative shift;
    // it is pinned at zero and left to the saturation stage instead.
    function automatic int unsigned shift_clamp(input int unsigned width,
                                                input int unsigned out_width,
                                                input int unsigned gain);
        if (gain > width - out_width) begin
            return 0;
        end
        return width - out_width - gain;
    endfunction

    function automatic logic signed [SAT_WIDTH-1:0] saturate(
        input logic signed [SAT_WIDTH-1:0] value,
        input int unsigned                 out_width);
        logic signed [SAT_WIDTH-1:0] hi;
        logic signed [SAT_WIDTH-1:0] lo;
        hi = (SAT_WIDTH'(1) << (out_width - 1)) - SAT_WIDTH'(1);
        lo = ~hi;
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/cic_integrator_chain.sv
// cic_integrator_chain: N cascaded clock-rate integrators.
//   clk - clock, rising edge
//   rst - synchronous active-high reset, clears every integrator
//   u   - zero-stuffed comb output injected into the first stage
//   y   - output of the last integrator
// Each stage adds the registered value of the previous stage, so an
// injection reaches y after N_STAGES clocks. Two's-complement wrap is
// harmless because the preceding comb section cancels it.
module cic_integrator_chain #(
    parameter int N_STAGES = 5,
    parameter int WIDTH    = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] u,
    output logic signed [WIDTH-1:0] y
);

    logic signed [WIDTH-1:0] integ [N_STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_STAGES; i++) begin
                integ[i] <= '0;
            end
        end else begin
            integ[0] <= integ[0] + u;
            for (int i = 1; i < N_STAGES; i++) begin
                integ[i] <= integ[i] + integ[i-1];
            end
        end
    end

    assign y = integ[N_STAGES-1];

endmodule

// File: rtl/cic_interpolator.sv
// cic_interpolator: CIC upsampler by INTERPOLATION_RATIO on a single clock.
//   clk         - clock, rising edge
//   rst         - synchronous active-high reset
//   Gain        - output scaling, shift = WIDTH - OUTPUT_WIDTH - Gain (min 0)
//   d_in        - signed input sample
//   d_in_valid  - source has a sample on d_in
//   d_in_ready  - strobe: d_in is taken this cycle (once every R clocks)
//   d_out       - signed, saturated output sample, one per clock
//   d_out_valid - sticky, high once valid data has reached d_out
//   underrun    - one-cycle pulse after a strobe that found no valid input
// Combs run once per accepted sample, the comb result is injected into the
// integrators only on the cycle after acceptance (zero-stuffing), and the
// integrators run every clock.
module cic_interpolator
    import cic_pkg::*;
#(
    parameter int INPUT_WIDTH         = 12,
    parameter int OUTPUT_WIDTH        = 12,
    parameter int WIDTH               = 64,
    parameter int INTERPOLATION_RATIO = 16,
    parameter int N_STAGES            = 5,
    parameter int GAIN_WIDTH          = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic        [GAIN_WIDTH-1:0]   Gain,
    input  logic signed [INPUT_WIDTH-1:0]  d_in,
    input  logic                           d_in_valid,
    output logic                           d_in_ready,
    output logic signed [OUTPUT_WIDTH-1:0] d_out,
    output logic                           d_out_valid,
    output logic                           underrun
);

    localparam int CW = count_width(INTERPOLATION_RATIO);
    localparam logic [CW-1:0] LAST_COUNT = CW'(INTERPOLATION_RATIO - 1);

    logic [CW-1:0]                  count;
    logic signed [WIDTH-1:0]        x;
    logic signed [WIDTH-1:0]        comb_out;
    logic signed [WIDTH-1:0]        u;
    logic signed [WIDTH-1:0]        integ_out;
    logic signed [WIDTH-1:0]        scaled;
    logic signed [OUTPUT_WIDTH-1:0] d_out_next;
    logic signed [WIDTH-1:0]        dly       [N_STAGES];
    logic signed [WIDTH-1:0]        stage_in  [N_STAGES];
    logic signed [WIDTH-1:0]        stage_out [N_STAGES];
    logic [N_STAGES:0]              valid_pipe;
    int unsigned                    sh;

    assign d_in_ready = !rst && (count == LAST_COUNT);

    // A starved strobe still clocks the comb, with a zero sample.
    assign x = d_in_valid ? {{(WIDTH-INPUT_WIDTH){d_in[INPUT_WIDTH-1]}}, d_in} : '0;

    // The whole comb cascade settles combinationally within the strobe cycle.
    always_comb begin
        stage_in[0]  = x;
        stage_out[0] = x - dly[0];
        for (int i = 1; i < N_STAGES; i++) begin
            stage_in[i]  = stage_out[i-1];
            stage_out[i] = stage_in[i] - dly[i];
        end
    end

    // Ratio is a power of two, so the counter wraps from R-1 to 0 by itself.
    // valid_pipe tracks the first valid sample through the comb register and
    // the N integrators so d_out_valid rises exactly with its first output.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            comb_out   <= '0;
            underrun   <= 1'b0;
            valid_pipe <= '0;
            for (int i = 0; i < N_STAGES; i++) begin
                dly[i] <= '0;
            end
        end else begin
            count      <= count + CW'(1);
            underrun   <= d_in_ready && !d_in_valid;
            valid_pipe <= {valid_pipe[N_STAGES-1:0], valid_pipe[0] | (d_in_ready & d_in_valid)};
            if (d_in_ready) begin
                comb_out <= stage_out[N_STAGES-1];
                for (int i = 0; i < N_STAGES; i++) begin
                    dly[i] <= stage_in[i];
                end
            end
        end
    end

    assign u = (count == '0) ? comb_out : '0;

    cic_integrator_chain #(
        .N_STAGES (N_STAGES),
        .WIDTH    (WIDTH)
    ) u_integrators (
        .clk (clk),
        .rst (rst),
        .u   (u),
        .y   (integ_out)
    );

    // Gain feeds the shifter directly so a change shows on the next d_out.
    always_comb begin
        sh         = shift_clamp(WIDTH, OUTPUT_WIDTH, 32'(Gain));
        scaled     = integ_out >>> sh;
        d_out_next = OUTPUT_WIDTH'(saturate(SAT_WIDTH'(scaled), OUTPUT_WIDTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_out       <= '0;
            d_out_valid <= 1'b0;
        end else begin
            d_out       <= d_out_next;
            d_out_valid <= d_out_valid | valid_pipe[N_STAGES];
        end
    end

endmodule

// File: tb/tb_cic_interpolator.sv
// tb_cic_interpolator: two instances share clk/rst.
//   small: N=1, R=4 (zero-order hold, impulse, starvation)
//   big  : N=5, R=16 defaults (step table, saturation, gain change)
// Both are compared every cycle against an impulse-response model: the
// full-rate output is the sum of accepted samples convolved with the
// N-fold boxcar of length R, delayed N+2 clocks from the strobe.
module tb_cic_interpolator;

    localparam int OW   = 12;
    localparam int W    = 64;
    localparam int BG_R = 16;
    localparam int BG_N = 5;
    localparam int SM_R = 4;
    localparam int SM_N = 1;

    typedef struct {
        int sample;
        int gain;
        int expected;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic        [7:0] bg_gain = 8'd36;
    logic        [7:0] sm_gain = 8'd52;
    logic signed [11:0] bg_d_in = '0;
    logic signed [11:0] sm_d_in = '0;
    logic              bg_valid = 1'b0;
    logic              sm_valid = 1'b0;
    logic signed [11:0] bg_d_out;
    logic signed [11:0] sm_d_out;
    logic              bg_ready, sm_ready;
    logic              bg_out_valid, sm_out_valid;
    logic              bg_underrun, sm_underrun;

    longint bg_xs[$];
    longint sm_xs[$];
    bit     bg_vs[$];
    bit     sm_vs[$];
    longint bg_h[$];
    longint sm_h[$];
    int     bg_prev_gain;
    int     sm_prev_gain;
    int     k;
    int     tests_run;
    int     tests_failed;

    always #5 clk = ~clk;

    cic_interpolator #(
        .INPUT_WIDTH (12), .OUTPUT_WIDTH (OW), .WIDTH (W),
        .INTERPOLATION_RATIO (BG_R), .N_STAGES (BG_N), .GAIN_WIDTH (8)
    ) dut_big (
        .clk (clk), .rst (rst), .Gain (bg_gain), .d_in (bg_d_in),
        .d_in_valid (bg_valid), .d_in_ready (bg_ready), .d_out (bg_d_out),
        .d_out_valid (bg_out_valid), .underrun (bg_underrun)
    );

    cic_interpolator #(
        .INPUT_WIDTH (12), .OUTPUT_WIDTH (OW), .WIDTH (W),
        .INTERPOLATION_RATIO (SM_R), .N_STAGES (SM_N), .GAIN_WIDTH (8)
    ) dut_small (
        .clk (clk), .rst (rst), .Gain (sm_gain), .d_in (sm_d_in),
        .d_in_valid (sm_valid), .d_in_ready (sm_ready), .d_out (sm_d_out),
        .d_out_valid (sm_out_valid), .underrun (sm_underrun)
    );

    task automatic check(input string name, input longint act, input longint exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, k, act, exp);
        end
    endtask

    function automatic void build_h(input int r, input int n, output longint h[$]);
        longint cur[$];
        longint nxt[$];
        cur = {1};
        for (int s = 0; s < n; s++) begin
            nxt = {};
            for (int i = 0; i < cur.size() + r - 1; i++) nxt.push_back(0);
            for (int i = 0; i < cur.size(); i++)
                for (int j = 0; j < r; j++) nxt[i+j] += cur[i];
            cur = nxt;
        end
        h = cur;
    endfunction

    function automatic void model(input longint xs[$], input bit vs[$], input longint h[$],
                                  input int r, input int n, input int kk, input int gain,
                                  output longint dout, output bit dvalid);
        longint v;
        int     idx;
        int     sh;
        v = 0;
        dvalid = 0;
        for (int j = 0; j < xs.size(); j++) begin
            idx = kk - ((j + 1) * r - 1 + n + 2);
            if (idx >= 0) begin
                if (vs[j]) dvalid = 1;
                if (idx < h.size()) v += xs[j] * h[idx];
            end
        end
        sh = (gain > W - OW) ? 0 : W - OW - gain;
        v = v >>> sh;
        dout = (v > 2047) ? 2047 : ((v < -2048) ? -2048 : v);
    endfunction

    task automatic checkOutput();
        longint e;
        bit     ev;
        bit     eu;
        model(bg_xs, bg_vs, bg_h, BG_R, BG_N, k, bg_prev_gain, e, ev);
        check("bg_d_out", bg_d_out, e);
        check("bg_d_out_valid", bg_out_valid, ev);
        check("bg_ready", bg_ready, (k % BG_R) == BG_R - 1);
        eu = 0;
        if (k >= 1 && ((k - 1) % BG_R) == BG_R - 1) eu = (bg_vs[bg_vs.size()-1] == 0);
        check("bg_underrun", bg_underrun, eu);
        model(sm_xs, sm_vs, sm_h, SM_R, SM_N, k, sm_prev_gain, e, ev);
        check("sm_d_out", sm_d_out, e);
        check("sm_d_out_valid", sm_out_valid, ev);
        check("sm_ready", sm_ready, (k % SM_R) == SM_R - 1);
        eu = 0;
        if (k >= 1 && ((k - 1) % SM_R) == SM_R - 1) eu = (sm_vs[sm_vs.size()-1] == 0);
        check("sm_underrun", sm_underrun, eu);
    endtask

    task automatic applyStimulus();
        if ((k % BG_R) == BG_R - 1) begin
            bg_xs.push_back(bg_valid ? longint'(bg_d_in) : 0);
            bg_vs.push_back(bg_valid);
        end
        if ((k % SM_R) == SM_R - 1) begin
            sm_xs.push_back(sm_valid ? longint'(sm_d_in) : 0);
            sm_vs.push_back(sm_valid);
        end
        bg_prev_gain = int'(bg_gain);
        sm_prev_gain = int'(sm_gain);
        @(negedge clk);
        k++;
    endtask

    task automatic step();
        checkOutput();
        applyStimulus();
    endtask

    // Called at a negedge: holds rst across one rising edge and checks that
    // everything is cleared while rst is still asserted.
    task automatic reset_dut();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_bg_d_out", bg_d_out, 0);
        check("rst_bg_valid", bg_out_valid, 0);
        check("rst_bg_underrun", bg_underrun, 0);
        check("rst_bg_ready", bg_ready, 0);
        check("rst_sm_d_out", sm_d_out, 0);
        check("rst_sm_valid", sm_out_valid, 0);
        check("rst_sm_underrun", sm_underrun, 0);
        check("rst_sm_ready", sm_ready, 0);
        rst = 1'b0;
        k = 0;
        bg_xs.delete(); bg_vs.delete();
        sm_xs.delete(); sm_vs.delete();
        bg_prev_gain = int'(bg_gain);
        sm_prev_gain = int'(sm_gain);
    endtask

    task automatic randomize_inputs();
        if ($urandom_range(0, 1) == 1) bg_d_in = 12'($urandom_range(0, 4095));
        else bg_d_in = 12'(int'($urandom_range(0, 63)) - 32);
        sm_d_in  = 12'($urandom_range(0, 4095));
        bg_valid = ($urandom_range(0, 9) != 0);
        sm_valid = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 49) == 0) bg_gain = 8'($urandom_range(30, 60));
        if ($urandom_range(0, 49) == 0) sm_gain = 8'($urandom_range(44, 56));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vectors [10];
        int   viol;
        bit   have_prev;
        int   prev;
        int   expd;

        tests_run = 0;
        tests_failed = 0;
        k = 0;
        build_h(BG_R, BG_N, bg_h);
        build_h(SM_R, SM_N, sm_h);

        vectors[0] = '{1, 36, 1};
        vectors[1] = '{100, 36, 100};
        vectors[2] = '{-100, 36, -100};
        vectors[3] = '{1, 40, 16};
        vectors[4] = '{-5, 37, -10};
        vectors[5] = '{2047, 52, 2047};
        vectors[6] = '{-2048, 52, -2048};
        vectors[7] = '{3, 60, 2047};
        vectors[8] = '{-1, 36, -1};
        vectors[9] = '{-3, 38, -12};

        @(negedge clk);

        // Zero-order hold on the small filter.
        bg_valid = 0; bg_d_in = '0; bg_gain = 8'd36; sm_gain = 8'd52;
        reset_dut();
        sm_d_in = 12'sd100; sm_valid = 1;
        for (int c = 0; c < 40; c++) begin
            if (k >= 6) check("zoh_d_out", sm_d_out, 100);
            check("zoh_underrun", sm_underrun, 0);
            step();
        end

        // Impulse: one 50 at strobe k=3, zeros afterwards.
        reset_dut();
        for (int c = 0; c < 24; c++) begin
            sm_d_in = (k < 4) ? 12'sd50 : 12'sd0;
            sm_valid = 1;
            check("impulse_d_out", sm_d_out, (k >= 6 && k <= 9) ? 50 : 0);
            step();
        end

        // Starvation at strobe k=7.
        reset_dut();
        sm_d_in = 12'sd100;
        for (int c = 0; c < 30; c++) begin
            sm_valid = (k != 7);
            if (k < 6) expd = 0;
            else if (k <= 9) expd = 100;
            else if (k <= 13) expd = 0;
            else expd = 100;
            check("starve_d_out", sm_d_out, expd);
            check("starve_underrun", sm_underrun, k == 8);
            step();
        end

        // Step / saturation table on the default-parameter filter.
        sm_valid = 0; sm_d_in = '0;
        for (int i = 0; i < 10; i++) begin
            bg_gain  = 8'(vectors[i].gain);
            reset_dut();
            bg_d_in  = 12'(vectors[i].sample);
            bg_valid = 1;
            viol = 0;
            have_prev = 0;
            prev = 0;
            for (int c = 0; c < 160; c++) begin
                if (bg_out_valid) begin
                    if (have_prev && ((vectors[i].sample >= 0 && int'(bg_d_out) < prev) ||
                                      (vectors[i].sample < 0 && int'(bg_d_out) > prev)))
                        viol++;
                    prev = int'(bg_d_out);
                    have_prev = 1;
                end
                step();
            end
            check("table_settle", bg_d_out, vectors[i].expected);
            check("table_monotonic", viol, 0);
        end

        // Gain change shows on the very next output.
        bg_gain = 8'd36;
        reset_dut();
        bg_d_in = 12'sd100; bg_valid = 1;
        for (int c = 0; c < 160; c++) step();
        check("gain_before", bg_d_out, 100);
        bg_gain = 8'd37;
        step();
        check("gain_after", bg_d_out, 200);
        for (int c = 0; c < 4; c++) step();

        // Random traffic with a mid-stream reset.
        reset_dut();
        for (int c = 0; c < 400; c++) begin
            randomize_inputs();
            step();
        end
        reset_dut();
        for (int c = 0; c < 400; c++) begin
            randomize_inputs();
            if (k < BG_R) check("post_rst_ready", bg_ready, k == BG_R - 1);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
